pipelined_ctrl_unit: RTL

//  Pipelined control path for the 5-stage RV32 core: decodes the ID-stage instruction into a control word,

---
 rtl/pipelined_ctrl_unit_pkg.sv | 61 ++++++
 rtl/pipelined_ctrl_unit_decoder.sv | 92 +++++++++
 rtl/pipelined_ctrl_unit.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/pipelined_ctrl_unit_pkg.sv
// ---------------------------------------------------------------------------
// cpu_ctrl_pkg
// Shared definitions for the RV32 pipelined control path: opcode constants,
// ALU-op and write-back source encodings, and the per-stage control-word
// structs that travel through the ID/EX, EX/MEM and MEM/WB registers.
// ---------------------------------------------------------------------------
package cpu_ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [1:0] {
    ALU_ADD    = 2'b00,
    ALU_BRANCH = 2'b01,
    ALU_RFUNCT = 2'b10,
    ALU_IFUNCT = 2'b11
  } aluop_e;

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_LOAD = 2'b01,
    WB_PC4  = 2'b10,
    WB_UIMM = 2'b11
  } memtoreg_e;

  typedef struct packed {
    logic   alusrc;
    logic   alu_a_pc;
    aluop_e aluop;
    logic   branch;
    logic   jump;
    logic   jalr;
  } ex_ctrl_t;

  typedef struct packed {
    logic memread;
    logic memwrite;
  } mem_ctrl_t;

  typedef struct packed {
    logic      regwrite;
    memtoreg_e memtoreg;
  } wb_ctrl_t;

  localparam ex_ctrl_t EX_NOP = '{alusrc: 1'b0, alu_a_pc: 1'b0, aluop: ALU_ADD,
                                  branch: 1'b0, jump: 1'b0, jalr: 1'b0};
  localparam mem_ctrl_t MEM_NOP = '{memread: 1'b0, memwrite: 1'b0};
  localparam wb_ctrl_t WB_NOP = '{regwrite: 1'b0, memtoreg: WB_ALU};

  function automatic logic is_mem_access(input mem_ctrl_t m);
    return m.memread | m.memwrite;
  endfunction

endpackage

// File: rtl/pipelined_ctrl_unit_decoder.sv
// ---------------------------------------------------------------------------
// ctrl_decoder
// Purely combinational opcode decode into the EX/MEM/WB control slices, plus
// which source registers the instruction reads and an unknown-opcode flag.
// Unknown opcodes produce an all-zero (NOP) control word.
//   opcode    in   7   instruction[6:0]
//   ex_ctrl   out      EX-stage control slice
//   mem_ctrl  out      MEM-stage control slice
//   wb_ctrl   out      WB-stage control slice
//   rs1_used  out  1   instruction reads rs1
//   rs2_used  out  1   instruction reads rs2
//   illegal   out  1   opcode not recognised
// ---------------------------------------------------------------------------
module ctrl_decoder
  import cpu_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output ex_ctrl_t   ex_ctrl,
  output mem_ctrl_t  mem_ctrl,
  output wb_ctrl_t   wb_ctrl,
  output logic       rs1_used,
  output logic       rs2_used,
  output logic       illegal
);

  always_comb begin
    ex_ctrl  = EX_NOP;
    mem_ctrl = MEM_NOP;
    wb_ctrl  = WB_NOP;
    rs1_used = 1'b0;
    rs2_used = 1'b0;
    illegal  = 1'b0;
    unique case (opcode)
      OP_R: begin
        ex_ctrl.aluop    = ALU_RFUNCT;
        wb_ctrl.regwrite = 1'b1;
        rs1_used         = 1'b1;
        rs2_used         = 1'b1;
      end
      OP_IALU: begin
        ex_ctrl.alusrc   = 1'b1;
        ex_ctrl.aluop    = ALU_IFUNCT;
        wb_ctrl.regwrite = 1'b1;
        rs1_used         = 1'b1;
      end
      OP_LOAD: begin
        ex_ctrl.alusrc   = 1'b1;
        mem_ctrl.memread = 1'b1;
        wb_ctrl.regwrite = 1'b1;
        wb_ctrl.memtoreg = WB_LOAD;
        rs1_used         = 1'b1;
      end
      OP_STORE: begin
        ex_ctrl.alusrc    = 1'b1;
        mem_ctrl.memwrite = 1'b1;
        rs1_used          = 1'b1;
        rs2_used          = 1'b1;
      end
      OP_BRANCH: begin
        ex_ctrl.aluop  = ALU_BRANCH;
        ex_ctrl.branch = 1'b1;
        rs1_used       = 1'b1;
        rs2_used       = 1'b1;
      end
      OP_JAL: begin
        ex_ctrl.jump     = 1'b1;
        wb_ctrl.regwrite = 1'b1;
        wb_ctrl.memtoreg = WB_PC4;
      end
      OP_JALR: begin
        ex_ctrl.alusrc   = 1'b1;
        ex_ctrl.jalr     = 1'b1;
        wb_ctrl.regwrite = 1'b1;
        wb_ctrl.memtoreg = WB_PC4;
        rs1_used         = 1'b1;
      end
      OP_LUI: begin
        wb_ctrl.regwrite = 1'b1;
        wb_ctrl.memtoreg = WB_UIMM;
      end
      OP_AUIPC: begin
        ex_ctrl.alusrc   = 1'b1;
        ex_ctrl.alu_a_pc = 1'b1;
        wb_ctrl.regwrite = 1'b1;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/pipelined_ctrl_unit.sv
// ---------------------------------------------------------------------------
// pipelined_ctrl_unit
// Control path of the 5-stage RV32 core. Decodes the ID-stage instruction,
// carries its control slices and rd through ID/EX, EX/MEM and MEM/WB, and
// resolves hazards with priority freeze > redirect > load-use.
//   clk, rst_n                   clock, async active-low reset
//   id_valid, id_instr           IF/ID register contents
//   ex_redirect                  EX resolved a taken branch/jump
//   mem_ready                    data memory completes MEM access this cycle
//   ex_valid, mem_valid, wb_valid  per-stage live flags
//   ex_alusrc, ex_alu_a_pc, ex_aluop, ex_branch, ex_jump, ex_jalr, ex_rd
//   mem_memread, mem_memwrite, mem_rd
//   wb_regwrite, wb_memtoreg, wb_rd
//   pc_hold                      hold PC and IF/ID this cycle
//   if_id_flush                  clear IF/ID valid at next edge
//   illegal_instr                one-cycle pulse: unknown opcode entered EX
// ---------------------------------------------------------------------------
module pipelined_ctrl_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int REG_AW      = 5,
  parameter bit LU_STALL_EN = 1'b1,
  parameter bit ILLEGAL_EN  = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [31:0]       id_instr,
  input  logic              ex_redirect,
  input  logic              mem_ready,
  output logic              ex_valid,
  output logic              mem_valid,
  output logic              wb_valid,
  output logic              ex_alusrc,
  output logic              ex_alu_a_pc,
  output logic [1:0]        ex_aluop,
  output logic              ex_branch,
  output logic              ex_jump,
  output logic              ex_jalr,
  output logic [REG_AW-1:0] ex_rd,
  output logic              mem_memread,
  output logic              mem_memwrite,
  output logic [REG_AW-1:0] mem_rd,
  output logic              wb_regwrite,
  output logic [1:0]        wb_memtoreg,
  output logic [REG_AW-1:0] wb_rd,
  output logic              pc_hold,
  output logic              if_id_flush,
  output logic              illegal_instr
);

  ex_ctrl_t    dec_ex;
  mem_ctrl_t   dec_mem;
  wb_ctrl_t    dec_wb;
  logic        dec_rs1_used;
  logic        dec_rs2_used;
  logic        dec_illegal;

  logic [REG_AW-1:0] id_rd;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;

  ex_ctrl_t    ex_ctrl_q;
  mem_ctrl_t   ex_mem_q;
  wb_ctrl_t    ex_wb_q;
  mem_ctrl_t   mem_ctrl_q;
  wb_ctrl_t    mem_wb_q;
  memtoreg_e   wb_memtoreg_q;

  logic freeze;
  logic rs_hit;
  logic lu_stall;
  logic issue;

  // funct3/funct7 are consumed by the datapath ALU control, not here
  logic unused_fields;
  assign unused_fields = ^{id_instr[31:25], id_instr[14:12]};

  assign id_rd  = id_instr[7 +: REG_AW];
  assign id_rs1 = id_instr[15 +: REG_AW];
  assign id_rs2 = id_instr[20 +: REG_AW];

  ctrl_decoder u_decoder (
    .opcode   (id_instr[6:0]),
    .ex_ctrl  (dec_ex),
    .mem_ctrl (dec_mem),
    .wb_ctrl  (dec_wb),
    .rs1_used (dec_rs1_used),
    .rs2_used (dec_rs2_used),
    .illegal  (dec_illegal)
  );

  // An outstanding memory access that cannot complete stalls everything,
  // including a pending redirect, which stays in EX and fires on release.
  assign freeze = mem_valid & is_mem_access(mem_ctrl_q) & ~mem_ready;

  // Only loads read memory, so ex_mem_q.memread identifies a load in EX.
  assign rs_hit = (dec_rs1_used & (id_rs1 == ex_rd)) |
                  (dec_rs2_used & (id_rs2 == ex_rd));
  assign lu_stall = LU_STALL_EN & ex_valid & ex_mem_q.memread &
                    (ex_rd != '0) & id_valid & rs_hit;

  assign issue = id_valid & ~ex_redirect & ~lu_stall;

  assign pc_hold     = freeze | (~ex_redirect & lu_stall);
  assign if_id_flush = ~freeze & ex_redirect;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid      <= 1'b0;
      ex_ctrl_q     <= EX_NOP;
      ex_mem_q      <= MEM_NOP;
      ex_wb_q       <= WB_NOP;
      ex_rd         <= '0;
      illegal_instr <= 1'b0;
      mem_valid     <= 1'b0;
      mem_ctrl_q    <= MEM_NOP;
      mem_wb_q      <= WB_NOP;
      mem_rd        <= '0;
      wb_valid      <= 1'b0;
      wb_regwrite   <= 1'b0;
      wb_memtoreg_q <= WB_ALU;
      wb_rd         <= '0;
    end else if (freeze) begin
      illegal_instr <= 1'b0;
    end else begin
      ex_valid      <= issue;
      ex_ctrl_q     <= issue ? dec_ex  : EX_NOP;
      ex_mem_q      <= issue ? dec_mem : MEM_NOP;
      ex_wb_q       <= issue ? dec_wb  : WB_NOP;
      ex_rd         <= issue ? id_rd   : '0;
      illegal_instr <= ILLEGAL_EN & issue & dec_illegal;

      mem_valid     <= ex_valid;
      mem_ctrl_q    <= ex_mem_q;
      mem_wb_q      <= ex_wb_q;
      mem_rd        <= ex_rd;

      // x0 is never written, so the write enable is squashed for rd == 0
      wb_valid      <= mem_valid;
      wb_regwrite   <= mem_valid & mem_wb_q.regwrite & (mem_rd != '0);
      wb_memtoreg_q <= mem_wb_q.memtoreg;
      wb_rd         <= mem_rd;
    end
  end

  assign ex_alusrc    = ex_ctrl_q.alusrc;
  assign ex_alu_a_pc  = ex_ctrl_q.alu_a_pc;
  assign ex_aluop     = ex_ctrl_q.aluop;
  assign ex_branch    = ex_ctrl_q.branch;
  assign ex_jump      = ex_ctrl_q.jump;
  assign ex_jalr      = ex_ctrl_q.jalr;
  assign mem_memread  = mem_valid & mem_ctrl_q.memread;
  assign mem_memwrite = mem_valid & mem_ctrl_q.memwrite;
  assign wb_memtoreg  = wb_memtoreg_q;

endmodule
